// File: rtl/c4_serial_sched.sv
// c4_serial_sched: two-requester round-robin scheduler for a WIDTH-bit
// serial shift link. A granted frame shifts tx out MSB first while shifting
// sdi into the receive register. One DONE cycle follows the frame.
module c4_serial_sched #(
   parameter int WIDTH = 8
) (
   input  logic             n_clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             abort,
   input  logic             sdi,
   output logic             gnt0,
   output logic             gnt1,
   output logic             m,
   output logic             sdo,
   output logic [WIDTH-1:0] rx_data,
   output logic             done,
   output logic             done_id,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] tx_q;
   logic [WIDTH-1:0] rx_q;
   logic [WIDTH-1:0] rx_data_q;
   logic [CW-1:0]    cnt_q;
   logic             owner_q;
   logic             last_q;     // 1 = requester 1 was granted last
   logic             done_id_q;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             win_d;

   // Round-robin winner: a lone request wins, a tie goes to the one not granted last.
   always_comb begin
      win_d = (req0 && req1) ? ~last_q : req1;
   end

   // Scheduler FSM and shift datapath; all state moves on the falling edge.
   always_ff @(negedge n_clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         done_id_q <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q <= SHIFT;
                  tx_q    <= win_d ? data1 : data0;
                  cnt_q   <= '0;
                  owner_q <= win_d;
                  last_q  <= win_d;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
               end
            end
            SHIFT: begin
               // Abort drops the frame silently; the pointer keeps the aborted grant.
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  tx_q  <= {tx_q[WIDTH-2:0], 1'b0};
                  rx_q  <= {rx_q[WIDTH-2:0], sdi};
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     state_q   <= DONE;
                     rx_data_q <= {rx_q[WIDTH-2:0], sdi};
                     done_id_q <= owner_q;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m       = (state_q == SHIFT);
   assign sdo     = m & tx_q[WIDTH-1];
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign rx_data = rx_data_q;
   assign done_id = done_id_q;

endmodule

// File: tb/tb_c4_serial_sched.sv
// Bench for c4_serial_sched: directed scenarios plus random traffic, all
// checked every cycle against a frame-level reference model.
module tb_c4_serial_sched;
   localparam int W = 8;

   logic         n_clk = 1'b0;
   logic         rst = 1'b0, req0 = 1'b0, req1 = 1'b0, abort = 1'b0, sdi = 1'b0;
   logic [W-1:0] data0 = '0, data1 = '0;
   logic         gnt0, gnt1, m, sdo, done, done_id, busy;
   logic [W-1:0] rx_data;

   c4_serial_sched #(.WIDTH(W)) dut (
      .n_clk(n_clk), .rst(rst), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .abort(abort), .sdi(sdi),
      .gnt0(gnt0), .gnt1(gnt1), .m(m), .sdo(sdo), .rx_data(rx_data),
      .done(done), .done_id(done_id), .busy(busy)
   );

   always #5 n_clk = ~n_clk;

   int n_tests = 0, n_fail = 0;

   // reference model: where the current frame is, and what it carries
   typedef enum {P_IDLE, P_SHIFT, P_DONE} phase_t;
   phase_t       ph = P_IDLE;
   int           k = 0;             // bits already sent in this frame
   logic [W-1:0] word = '0, rxacc = '0, e_rx = '0, sdi_pat = '0, sdo_cap = '0;
   logic         owner = 1'b0, last = 1'b1, e_id = 1'b0, e_g0 = 1'b0, e_g1 = 1'b0;
   logic         prev_done = 1'b0;
   int           cyc = 0, gnt_cyc = 0, done_cyc = 0;
   int           gq[$];
   int           dq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic win;
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (!rst) begin
         ph = P_IDLE; k = 0; word = '0; rxacc = '0; e_rx = '0;
         e_id = 1'b0; owner = 1'b0; last = 1'b1;
      end else begin
         case (ph)
            P_IDLE: if (req0 || req1) begin
               if (req0 && req1) win = ~last;
               else              win = req1;
               word  = win ? data1 : data0;
               owner = win;
               last  = win;
               e_g0  = !win;
               e_g1  = win;
               rxacc = '0;
               k     = 0;
               ph    = P_SHIFT;
            end
            P_SHIFT: begin
               if (abort) ph = P_IDLE;
               else begin
                  rxacc = {rxacc[W-2:0], sdi};
                  k++;
                  if (k == W) begin
                     ph   = P_DONE;
                     e_rx = rxacc;
                     e_id = owner;
                  end
               end
            end
            default: ph = P_IDLE;
         endcase
      end
   endtask

   task automatic check_outputs();
      logic e_m, e_sdo;
      e_m   = (ph == P_SHIFT);
      e_sdo = e_m ? word[W-1-k] : 1'b0;
      chk("gnt0", gnt0, e_g0);
      chk("gnt1", gnt1, e_g1);
      chk("m", m, e_m);
      chk("sdo", sdo, e_sdo);
      chk("busy", busy, ph != P_IDLE);
      chk("done", done, ph == P_DONE);
      chk("rx_data", rx_data, e_rx);
      chk("done_id", done_id, e_id);
      if (!done) chk("a_m_eq_busy", m, busy);
      if (!m) chk("a_sdo_quiet", sdo, 0);
      chk("a_gnt_excl", gnt0 & gnt1, 0);
      chk("a_done_gnt", done & (gnt0 | gnt1), 0);
      chk("a_done_width", done & prev_done, 0);
      prev_done = done;
   endtask

   // one clock: DUT and model update on the falling edge, compare on the rising edge
   task automatic tick();
      @(negedge n_clk);
      model_step();
      @(posedge n_clk);
      cyc++;
      check_outputs();
      if (m) sdo_cap = {sdo_cap[W-2:0], sdo};
      if (gnt0 || gnt1) begin gnt_cyc = cyc; gq.push_back(gnt1 ? 1 : 0); end
      if (done) begin done_cyc = cyc; dq.push_back(int'(done_id)); end
      if (ph == P_SHIFT) sdi = sdi_pat[W-1-k];
      else               sdi = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_rx", rx_data, 0);
      chk("rst_busy", busy, 0);

      // single frame from requester 0
      req0 = 1'b1; data0 = 8'hA5; sdi_pat = 8'h3C; sdo_cap = '0;
      tick();
      chk("s1_gnt0", gnt0, 1);
      req0 = 1'b0;
      repeat (W + 1) tick();
      chk("s1_sdo", sdo_cap, 8'hA5);
      chk("s1_rx", rx_data, 8'h3C);
      chk("s1_id", done_id, 0);
      chk("s1_latency", done_cyc - gnt_cyc + 1, W + 1);

      // tie after reset: 0,1,0 with done_id following
      do_reset();
      gq.delete(); dq.delete();
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h5A; data1 = 8'hC3; sdi_pat = 8'h96;
      repeat (3 * (W + 2)) tick();
      req0 = 1'b0; req1 = 1'b0;
      chk("tie_ngnt", gq.size(), 3);
      chk("tie_ndone", dq.size(), 3);
      if (gq.size() == 3) begin
         chk("tie_g0", gq[0], 0); chk("tie_g1", gq[1], 1); chk("tie_g2", gq[2], 0);
      end
      if (dq.size() == 3) begin
         chk("tie_d0", dq[0], 0); chk("tie_d1", dq[1], 1); chk("tie_d2", dq[2], 0);
      end
      tick();

      // requester 1 alone, all ones out, zeros in
      req1 = 1'b1; data1 = 8'hFF; sdi_pat = 8'h00; sdo_cap = '0;
      tick();
      chk("s3_gnt1", gnt1, 1);
      req1 = 1'b0;
      repeat (W + 1) tick();
      chk("s3_sdo", sdo_cap, 8'hFF);
      chk("s3_rx", rx_data, 8'h00);
      chk("s3_id", done_id, 1);

      // abort on the 4th shift cycle
      req0 = 1'b1; data0 = 8'h7E; sdi_pat = 8'hE1;
      tick();
      req0 = 1'b0;
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_m", m, 0);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      chk("ab_rx_hold", rx_data, 8'h00);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_idle_ignored", busy, 0);
      // the aborted grant still counts, so a tie now goes to requester 1
      req0 = 1'b1; req1 = 1'b1;
      tick();
      chk("ab_tie_gnt1", gnt1, 1);
      req0 = 1'b0; req1 = 1'b0;
      repeat (W + 1) tick();

      // reset on the 5th shift cycle
      req0 = 1'b1; data0 = 8'h3F; sdi_pat = 8'hAA;
      tick();
      req0 = 1'b0;
      repeat (4) tick();
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      tick();
      chk("mr_m", m, 0); chk("mr_busy", busy, 0); chk("mr_rx", rx_data, 0);
      chk("mr_id", done_id, 0); chk("mr_gnt", gnt0 | gnt1, 0);
      rst = 1'b1;
      tick();
      chk("mr_tie_gnt0", gnt0, 1);
      req0 = 1'b0; req1 = 1'b0;
      repeat (W + 1) tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         req0  = ($urandom_range(0, 3) != 0);
         req1  = ($urandom_range(0, 3) != 0);
         data0 = W'($urandom);
         data1 = W'($urandom);
         abort = ($urandom_range(0, 19) == 0);
         rst   = ($urandom_range(0, 79) != 0);
         if (ph == P_IDLE) sdi_pat = W'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/c4_serial_sched.md
C4_SERIAL_SCHED -- requirements
Module: c4_serial_sched

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits and width of both data ports.
REQ-002 n_clk  input  1  clock; every register updates on the falling edge of n_clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1  requests for the serial link from requester 0 and requester 1.
REQ-005 data0, data1  input  WIDTH  transmit words for requester 0 and requester 1.
REQ-006 abort  input  1  cancels the frame in progress.
REQ-007 sdi  input  1  serial receive bit from the shift datapath.
REQ-008 gnt0, gnt1  output  1  one-cycle grant pulses.
REQ-009 m  output  1  shift-mode enable to the datapath.
REQ-010 sdo  output  1  serial transmit bit, MSB first.
REQ-011 rx_data  output  WIDTH  last completed received word.
REQ-012 done  output  1  one-cycle frame-complete pulse.
REQ-013 done_id  output  1  owner of the completed frame (0/1).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 IDLE with neither request active SHALL stay in IDLE.
REQ-017 IDLE with any request active SHALL, at the next edge, do all of the following:
- enter SHIFT;
- load tx_reg from the winner's data word;
- clear the bit counter;
- record the owner;
- pulse the winner's gnt for exactly one cycle.
REQ-018 Arbitration SHALL be round-robin:
- a single active request always wins;
- when both are active, the requester not granted last wins;
- the last-grant pointer updates only on a grant.
REQ-019 Requests SHALL be sampled only in IDLE; requests during SHIFT or DONE are ignored, not queued.
REQ-020 In SHIFT, m=1 and sdo=tx_reg[WIDTH-1] combinationally.
REQ-021 At each edge in SHIFT:
- tx_reg shifts left by one with a 0 fill;
- rx_reg <= {rx_reg[WIDTH-2:0], sdi};
- the bit counter increments.
REQ-022 SHIFT SHALL last exactly WIDTH cycles.
REQ-023 At the edge where the counter equals WIDTH-1:
- state <= DONE;
- rx_data <= {rx_reg[WIDTH-2:0], sdi};
- done_id <= owner.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 Grant-to-done latency SHALL be WIDTH+1 cycles.
REQ-026 Back-to-back frames SHALL be separated by at least one IDLE cycle.
REQ-027 abort=1 at an edge in SHIFT SHALL force IDLE at that edge:
- no done pulse;
- rx_data and done_id unchanged;
- last-grant pointer keeps the aborted grant.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 Outside SHIFT, m=0 and sdo=0.
REQ-030 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-031 done SHALL never coincide with gnt0 or gnt1.

Reset
REQ-032 rst=0 at a falling edge SHALL override every other input, including mid-frame.
REQ-033 On reset the following SHALL be cleared:
- state to IDLE;
- gnt0, gnt1, m, sdo, done, done_id and busy to 0;
- rx_data, tx_reg, rx_reg and the counter to 0;
- the last-grant pointer set so that req1 is considered last granted, meaning req0 wins the first tie.
REQ-034 The first edge with rst=1 SHALL evaluate IDLE normally.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Single frame: reset; req0=1, data0=8'hA5; sdi drives 8'h3C MSB first -> gnt0 for 1 cycle; m=1 for 8 cycles; sdo=1,0,1,0,0,1,0,1; done 1 cycle later; rx_data=8'h3C; done_id=0.
- Tie and rotation: req0=req1=1 held after reset -> grants in the order gnt0, gnt1, gnt0; one IDLE cycle between frames; done_id alternates 0,1,0.
- Requester 1 alone: req1=1, data1=8'hFF, sdi=0 -> sdo all ones for 8 cycles; rx_data=8'h00; done_id=1.
- Abort: abort=1 on the 4th SHIFT cycle -> IDLE at the next edge; m=0, busy=0, no done; rx_data holds its previous value.
- Reset mid-frame: rst=0 on the 5th SHIFT cycle -> all outputs 0 at the next edge; after release, a tie grants req0.
- Assertions: m==busy except in DONE; sdo==0 whenever m==0; done width is exactly 1 cycle.
